mcpu_ctrl: RTL and testbench

Multi-cycle MIPS control unit: the next generation after the single-cycle SCPU controller. It decodes OPcode/Fun over several states and sequences a shared-memory datapath. It stalls on the MIO_ready memory handshake and traps illegal instructions or memory timeouts into a sticky error state. It sits between the instruction register and the multi-cycle datapath; CPU_MIO/MIO_ready connect to the MIO bus.

---
 rtl/mcpu_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_mcpu_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_ctrl.sv
// Multi-cycle MIPS control unit: sequences a shared-memory datapath, stalls on the
// MIO_ready handshake and traps illegal instructions or memory timeouts into ERR.
module mcpu_ctrl #(
    parameter int ALU_CTRL_W = 3,
    parameter int WAIT_MAX   = 15,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            OPcode,
    input  logic [5:0]            Fun,
    input  logic                  MIO_ready,
    output logic                  CPU_MIO,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic                  IorD,
    output logic                  IRWrite,
    output logic                  PCWrite,
    output logic                  Branch,
    output logic                  BranchN,
    output logic [1:0]            PCSource,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [ALU_CTRL_W-1:0] ALU_Control,
    output logic                  RegWrite,
    output logic [1:0]            RegDst,
    output logic [1:0]            MemtoReg,
    output logic [3:0]            state,
    output logic                  err
);

    typedef enum logic [3:0] {
        S_IF  = 4'd0,  S_ID  = 4'd1,  S_MA  = 4'd2,  S_MRD = 4'd3,
        S_WBL = 4'd4,  S_MWR = 4'd5,  S_EXR = 4'd6,  S_WBR = 4'd7,
        S_BR  = 4'd8,  S_JMP = 4'd9,  S_EXI = 4'd10, S_WBI = 4'd11,
        S_JAL = 4'd12, S_ERR = 4'd13
    } state_t;

    localparam logic [2:0] ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_ADD = 3'b010,
                           ALU_XOR = 3'b011, ALU_NOR = 3'b100, ALU_SRL = 3'b101,
                           ALU_SUB = 3'b110, ALU_SLT = 3'b111;

    localparam logic [5:0] OP_R    = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                           OP_BEQ  = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                           OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D,
                           OP_XORI = 6'h0E, OP_LUI  = 6'h0F, OP_LW   = 6'h23,
                           OP_SW   = 6'h2B;

    localparam logic [CNT_W-1:0] WAIT_LAST = (WAIT_MAX > 0) ? CNT_W'(WAIT_MAX - 1) : '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [2:0] r_alu;
    logic       r_legal;
    logic [2:0] i_alu;
    logic [2:0] alu_op;
    logic       timeout;
    logic       in_mem;

    always_comb begin
        r_legal = 1'b1;
        r_alu   = ALU_ADD;
        case (Fun)
            6'h20:   r_alu = ALU_ADD;
            6'h22:   r_alu = ALU_SUB;
            6'h24:   r_alu = ALU_AND;
            6'h25:   r_alu = ALU_OR;
            6'h26:   r_alu = ALU_XOR;
            6'h27:   r_alu = ALU_NOR;
            6'h2A:   r_alu = ALU_SLT;
            6'h02:   r_alu = ALU_SRL;
            default: r_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (OPcode)
            OP_ANDI: i_alu = ALU_AND;
            OP_ORI:  i_alu = ALU_OR;
            OP_XORI: i_alu = ALU_XOR;
            OP_SLTI: i_alu = ALU_SLT;
            default: i_alu = ALU_ADD;
        endcase
    end

    // A ready in the last allowed wait cycle completes the access instead of trapping.
    assign timeout = (WAIT_MAX > 0) && !MIO_ready && (cnt_q == WAIT_LAST);
    assign in_mem  = (state_q == S_IF) || (state_q == S_MRD) || (state_q == S_MWR);

    always_comb begin
        state_d  = state_q;
        CPU_MIO  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        Branch   = 1'b0;
        BranchN  = 1'b0;
        PCSource = 2'b00;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        alu_op   = ALU_AND;
        RegWrite = 1'b0;
        RegDst   = 2'b00;
        MemtoReg = 2'b00;

        case (state_q)
            S_IF: begin
                CPU_MIO = 1'b1;
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                alu_op  = ALU_ADD;
                IRWrite = MIO_ready;
                PCWrite = MIO_ready;
                if (MIO_ready)    state_d = S_ID;
                else if (timeout) state_d = S_ERR;
            end
            S_ID: begin
                ALUSrcB = 2'b11;
                alu_op  = ALU_ADD;
                case (OPcode)
                    OP_LW, OP_SW:   state_d = S_MA;
                    OP_R:           state_d = r_legal ? S_EXR : S_ERR;
                    OP_BEQ, OP_BNE: state_d = S_BR;
                    OP_J:           state_d = S_JMP;
                    OP_JAL:         state_d = S_JAL;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI:
                                    state_d = S_EXI;
                    default:        state_d = S_ERR;
                endcase
            end
            S_MA: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                alu_op  = ALU_ADD;
                state_d = (OPcode == OP_SW) ? S_MWR : S_MRD;
            end
            S_MRD: begin
                CPU_MIO = 1'b1;
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MIO_ready)    state_d = S_WBL;
                else if (timeout) state_d = S_ERR;
            end
            S_WBL: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
                state_d  = S_IF;
            end
            S_MWR: begin
                CPU_MIO  = 1'b1;
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MIO_ready)    state_d = S_IF;
                else if (timeout) state_d = S_ERR;
            end
            S_EXR: begin
                ALUSrcA = 1'b1;
                alu_op  = r_alu;
                state_d = S_WBR;
            end
            S_WBR: begin
                RegWrite = 1'b1;
                RegDst   = 2'b01;
                state_d  = S_IF;
            end
            S_BR: begin
                ALUSrcA  = 1'b1;
                alu_op   = ALU_SUB;
                PCSource = 2'b01;
                Branch   = (OPcode == OP_BEQ);
                BranchN  = (OPcode == OP_BNE);
                state_d  = S_IF;
            end
            S_JMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = S_IF;
            end
            S_JAL: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
                state_d  = S_IF;
            end
            S_EXI: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                alu_op  = i_alu;
                state_d = S_WBI;
            end
            S_WBI: begin
                RegWrite = 1'b1;
                MemtoReg = (OPcode == OP_LUI) ? 2'b11 : 2'b00;
                state_d  = S_IF;
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if ((state_d != state_q) &&
            ((state_d == S_IF) || (state_d == S_MRD) || (state_d == S_MWR)))
            cnt_d = '0;
        else if (in_mem && !MIO_ready && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
        err_d = err_q | (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IF;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign ALU_Control = ALU_CTRL_W'(alu_op);
    assign state       = state_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Scoreboard bench for mcpu_ctrl: instructions expand into expected per-cycle
// control words that a negedge monitor pops and compares.
module tb_mcpu_ctrl;

    localparam int WAIT_MAX = 15;

    localparam int ST_IF = 0, ST_ID = 1, ST_MA = 2, ST_MRD = 3, ST_WBL = 4, ST_MWR = 5,
                   ST_EXR = 6, ST_WBR = 7, ST_BR = 8, ST_JMP = 9, ST_EXI = 10,
                   ST_WBI = 11, ST_JAL = 12, ST_ERR = 13;

    typedef struct packed {
        logic       cpu, mrd, mwr, iord, irw, pcw, br, brn;
        logic [1:0] pcs;
        logic       srca;
        logic [1:0] srcb;
        logic [2:0] alu;
        logic       rw;
        logic [1:0] rd, m2r;
        logic [3:0] st;
        logic       err;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] OPcode, Fun;
    logic       MIO_ready;
    logic       CPU_MIO, MemRead, MemWrite, IorD, IRWrite, PCWrite, Branch, BranchN;
    logic [1:0] PCSource, ALUSrcB, RegDst, MemtoReg;
    logic       ALUSrcA, RegWrite, err;
    logic [2:0] ALU_Control;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;
    ctl_t exp_q[$];

    always #5 clk = ~clk;

    mcpu_ctrl #(.ALU_CTRL_W(3), .WAIT_MAX(WAIT_MAX), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .OPcode(OPcode), .Fun(Fun), .MIO_ready(MIO_ready),
        .CPU_MIO(CPU_MIO), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch), .BranchN(BranchN),
        .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALU_Control(ALU_Control), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .state(state), .err(err)
    );

    function automatic bit fun_ok(logic [5:0] f);
        return f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h02};
    endfunction

    function automatic logic [2:0] fun_alu(logic [5:0] f);
        case (f)
            6'h20: return 3'b010;
            6'h22: return 3'b110;
            6'h24: return 3'b000;
            6'h25: return 3'b001;
            6'h26: return 3'b011;
            6'h27: return 3'b100;
            6'h2A: return 3'b111;
            default: return 3'b101;
        endcase
    endfunction

    function automatic logic [2:0] imm_alu(logic [5:0] op);
        case (op)
            6'h0C: return 3'b000;
            6'h0D: return 3'b001;
            6'h0E: return 3'b011;
            6'h0A: return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic ctl_t expect_ctl(int st, logic [5:0] op, logic [5:0] f, logic rdy);
        ctl_t c = '0;
        c.st = 4'(st);
        case (st)
            ST_IF:  begin c.cpu = 1; c.mrd = 1; c.srcb = 2'b01; c.alu = 3'b010;
                          c.irw = rdy; c.pcw = rdy; end
            ST_ID:  begin c.srcb = 2'b11; c.alu = 3'b010; end
            ST_MA:  begin c.srca = 1; c.srcb = 2'b10; c.alu = 3'b010; end
            ST_MRD: begin c.cpu = 1; c.mrd = 1; c.iord = 1; end
            ST_WBL: begin c.rw = 1; c.m2r = 2'b01; end
            ST_MWR: begin c.cpu = 1; c.mwr = 1; c.iord = 1; end
            ST_EXR: begin c.srca = 1; c.alu = fun_alu(f); end
            ST_WBR: begin c.rw = 1; c.rd = 2'b01; end
            ST_BR:  begin c.srca = 1; c.alu = 3'b110; c.pcs = 2'b01;
                          c.br = (op == 6'h04); c.brn = (op == 6'h05); end
            ST_JMP: begin c.pcw = 1; c.pcs = 2'b10; end
            ST_JAL: begin c.pcw = 1; c.pcs = 2'b10; c.rw = 1; c.rd = 2'b10; c.m2r = 2'b10; end
            ST_EXI: begin c.srca = 1; c.srcb = 2'b10; c.alu = imm_alu(op); end
            ST_WBI: begin c.rw = 1; c.m2r = (op == 6'h0F) ? 2'b11 : 2'b00; end
            default: c.err = 1;
        endcase
        return c;
    endfunction

    always @(negedge clk) begin
        ctl_t e, a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {CPU_MIO, MemRead, MemWrite, IorD, IRWrite, PCWrite, Branch, BranchN,
                 PCSource, ALUSrcA, ALUSrcB, ALU_Control, RegWrite, RegDst, MemtoReg,
                 state, err};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL ctl st=%0d t=%0t: got %h expected %h", e.st, $time, a, e);
            end
        end
    end

    task automatic cycle(int st, logic [5:0] op, logic [5:0] f, logic rdy);
        OPcode = op; Fun = f; MIO_ready = rdy;
        exp_q.push_back(expect_ctl(st, op, f, rdy));
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        MIO_ready = 1'($urandom_range(0, 1));
        #1;
        checks++;
        if (state !== 4'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got state=%0d err=%b expected state=0 err=0", state, err);
        end
        exp_q.push_back(expect_ctl(ST_IF, OPcode, Fun, MIO_ready));
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic err_tail(logic [5:0] op, logic [5:0] f);
        for (int i = 0; i < 3; i++) cycle(ST_ERR, op, f, 1'($urandom_range(0, 1)));
        do_reset();
    endtask

    // Memory phase: w not-ready cycles then ready, or a trap once WAIT_MAX is used up.
    task automatic mem_phase(int st, logic [5:0] op, logic [5:0] f, int w, bit rst_mid,
                             output bit dead);
        bit tmo;
        int n;
        dead = 0;
        tmo  = (WAIT_MAX > 0) && (w >= WAIT_MAX);
        n    = tmo ? WAIT_MAX : w;
        for (int k = 0; k < n; k++) begin
            if (rst_mid && k == 1) begin
                do_reset();
                dead = 1;
                return;
            end
            cycle(st, op, f, 1'b0);
        end
        if (tmo) begin
            err_tail(op, f);
            dead = 1;
            return;
        end
        cycle(st, op, f, 1'b1);
    endtask

    task automatic run_instr(logic [5:0] op, logic [5:0] f, int wif, int wmem, bit rst_mid);
        bit dead;
        logic r;
        mem_phase(ST_IF, op, f, wif, 1'b0, dead);
        if (dead) return;
        r = 1'($urandom_range(0, 1));
        cycle(ST_ID, op, f, r);
        r = 1'($urandom_range(0, 1));
        case (op)
            6'h23: begin
                cycle(ST_MA, op, f, r);
                mem_phase(ST_MRD, op, f, wmem, rst_mid, dead);
                if (!dead) cycle(ST_WBL, op, f, 1'($urandom_range(0, 1)));
            end
            6'h2B: begin
                cycle(ST_MA, op, f, r);
                mem_phase(ST_MWR, op, f, wmem, 1'b0, dead);
            end
            6'h00: begin
                if (fun_ok(f)) begin
                    cycle(ST_EXR, op, f, r);
                    cycle(ST_WBR, op, f, 1'($urandom_range(0, 1)));
                end else err_tail(op, f);
            end
            6'h04, 6'h05: cycle(ST_BR, op, f, r);
            6'h02:        cycle(ST_JMP, op, f, r);
            6'h03:        cycle(ST_JAL, op, f, r);
            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                cycle(ST_EXI, op, f, r);
                cycle(ST_WBI, op, f, 1'($urandom_range(0, 1)));
            end
            default: err_tail(op, f);
        endcase
    endtask

    initial begin
        logic [5:0] ops [14];
        logic [5:0] funs [8];
        logic [5:0] op, f;
        int wi, wm;
        ops  = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08,
                 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0F, 6'h00};
        funs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h02};
        rst_n = 1'b0; OPcode = '0; Fun = '0; MIO_ready = 1'b0;
        @(posedge clk); #1;
        do_reset();

        run_instr(6'h00, 6'h20, 0, 0, 0);
        run_instr(6'h23, 6'h00, 0, 3, 0);
        run_instr(6'h2B, 6'h00, 0, 20, 0);
        run_instr(6'h2B, 6'h00, 0, 14, 0);
        run_instr(6'h04, 6'h00, 0, 0, 0);
        run_instr(6'h05, 6'h00, 0, 0, 0);
        run_instr(6'h03, 6'h00, 0, 0, 0);
        run_instr(6'h0F, 6'h00, 0, 0, 0);
        run_instr(6'h00, 6'h3F, 0, 0, 0);
        run_instr(6'h3F, 6'h00, 0, 0, 0);
        run_instr(6'h23, 6'h00, 0, 5, 1);
        run_instr(6'h08, 6'h00, 15, 0, 0);

        for (int i = 0; i < 200; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 13)];
            f  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : funs[$urandom_range(0, 7)];
            wi = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(0, 18);
            wm = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(0, 18);
            run_instr(op, f, wi, wm, $urandom_range(0, 15) == 0);
        end

        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
